// File: rtl/param_id_tagger.sv
// -----------------------------------------------------------------------------
// param_id_tagger
//
// Upstream stage for the data/id consumer. Each beat accepted on the input
// valid/ready handshake is stamped with a sequential ID. The {data, id} pair is
// buffered in a small show-ahead FIFO and presented on the output valid/ready
// handshake.
//
// Parameters
//   DATA_WIDTH : payload width
//   ID_WIDTH   : sequence ID width (the counter wraps at 2^ID_WIDTH)
//   DEPTH      : FIFO entries, power of two, >= 2
//
// Ports
//   clk             : single clock, all logic on the rising edge
//   rst_n           : synchronous active-low reset
//   in_valid        : upstream beat present
//   in_ready        : a beat can be accepted this cycle
//   in_data         : upstream payload
//   id_clear        : restart the ID sequence at 0
//   out_valid       : head entry available
//   out_ready       : downstream consumes the head this cycle
//   out_data        : head payload (holds the last head value while empty)
//   out_id          : head ID (holds the last head value while empty)
//   level           : current FIFO occupancy, 0..DEPTH
//   overflow_sticky : a beat arrived while full; cleared only by reset
// -----------------------------------------------------------------------------
module param_id_tagger #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        id_clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [ID_WIDTH-1:0]         out_id,
    output logic [$clog2(DEPTH)+1-1:0]  level,
    output logic                        overflow_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Storage: payload and ID kept side by side per slot.
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [ID_WIDTH-1:0]   id_cnt;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [ID_WIDTH-1:0]   tag;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [LW-1:0]         level_nxt;
    logic [DATA_WIDTH-1:0] head_data_nxt;
    logic [ID_WIDTH-1:0]   head_id_nxt;

    // Handshake and status, all derived from registered state (plus rst_n for
    // in_ready). out_ready never reaches in_ready, so a full FIFO refuses a
    // beat even when the head is popped in the same cycle.
    always_comb begin
        full      = (level == FULL_LVL);
        empty     = (level == '0);
        in_ready  = !full && rst_n;
        out_valid = !empty;
        push      = in_valid && !full;
        pop       = !empty && out_ready;
        tag       = id_clear ? '0 : id_cnt;
    end

    // Next head selection. The output registers always hold the entry that
    // will sit at the head after this edge. When the FIFO will be empty the
    // registers keep their previous value. When every older entry is being
    // drained, the beat written this cycle becomes the head and is taken
    // straight from the input, since the memory does not hold it yet.
    always_comb begin
        rd_ptr_nxt    = rd_ptr + PW'(pop);
        level_nxt     = level + LW'(push) - LW'(pop);
        head_data_nxt = out_data;
        head_id_nxt   = out_id;
        if (level_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                head_data_nxt = in_data;
                head_id_nxt   = tag;
            end else begin
                head_data_nxt = mem_data[rd_ptr_nxt];
                head_id_nxt   = mem_id[rd_ptr_nxt];
            end
        end
    end

    // Control state: pointers, occupancy, ID counter, sticky flag and the
    // head registers. Reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            id_cnt          <= '0;
            overflow_sticky <= 1'b0;
            out_data        <= '0;
            out_id          <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            out_data <= head_data_nxt;
            out_id   <= head_id_nxt;

            // A clear coincident with an accept tags the beat 0 and continues
            // from 1; a refused beat leaves the counter untouched.
            if (push) begin
                id_cnt <= tag + ID_WIDTH'(1);
            end else if (id_clear) begin
                id_cnt <= '0;
            end

            if (in_valid && full) begin
                overflow_sticky <= 1'b1;
            end
        end
    end

    // Storage writes carry no reset; stale slots are unreachable because the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_id[wr_ptr]   <= tag;
        end
    end

endmodule
